// File: rtl/i2c_pkg.sv
// Shared types for the codec I2C init sequencer: operation codes and FSM states.
package i2c_pkg;

  typedef enum logic [2:0] {
    OP_RESET = 3'd0,
    OP_AAPC  = 3'd1,
    OP_DAPC  = 3'd2,
    OP_PDC   = 3'd3,
    OP_DAIF  = 3'd4,
    OP_SC    = 3'd5,
    OP_AC    = 3'd6
  } op_e;

  localparam int NUM_OPS = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Sequences the codec I2C initializer: seven-op boot with watchdog and retry,
// then single runtime operations arbitrated onto the same initializer.
module i2c_init_sequencer #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYC     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_boot,
  input  logic       i_req,
  input  logic [2:0] i_req_op,
  output logic       o_req_ack,
  output logic       o_i2c_start,
  output logic [2:0] o_i2c_op,
  input  logic       i_i2c_finished,
  output logic       o_init_done,
  output logic       o_busy,
  output logic       o_error,
  output logic [2:0] o_fail_op
);
  import i2c_pkg::*;

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Timers are loaded with N-1 so that done is sampled on the Nth edge after entry
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
  localparam logic [2:0]       LAST_OP  = 3'(NUM_OPS - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic              boot_mode_q, boot_mode_d;
  logic              gap_to_idle_q, gap_to_idle_d;
  logic              ack_d, start_d, busy_d, done_d, err_d;
  logic [2:0]        fail_d;
  logic              wd_load, gap_load, wd_done, gap_done;

  cycle_timer #(.W(WD_W)) u_watchdog (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (wd_load),
    .load_val (WD_LOAD),
    .done     (wd_done)
  );

  cycle_timer #(.W(GAP_W)) u_gap (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .done     (gap_done)
  );

  // State, sequencing context and all outputs are registered here
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      retry_q       <= '0;
      boot_mode_q   <= 1'b0;
      gap_to_idle_q <= 1'b0;
      o_req_ack     <= 1'b0;
      o_i2c_start   <= 1'b0;
      o_i2c_op      <= '0;
      o_init_done   <= 1'b0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
      o_fail_op     <= '0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      boot_mode_q   <= boot_mode_d;
      gap_to_idle_q <= gap_to_idle_d;
      o_req_ack     <= ack_d;
      o_i2c_start   <= start_d;
      o_i2c_op      <= op_d;
      o_init_done   <= done_d;
      o_busy        <= busy_d;
      o_error       <= err_d;
      o_fail_op     <= fail_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    op_d          = o_i2c_op;
    retry_d       = retry_q;
    boot_mode_d   = boot_mode_q;
    gap_to_idle_d = gap_to_idle_q;
    ack_d         = 1'b0;
    done_d        = o_init_done;
    err_d         = o_error;
    fail_d        = o_fail_op;
    wd_load       = 1'b0;
    gap_load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_boot) begin
          err_d       = 1'b0;
          done_d      = 1'b0;
          op_d        = OP_RESET;
          retry_d     = '0;
          boot_mode_d = 1'b1;
          wd_load     = 1'b1;
          state_d     = ST_ISSUE;
        // The ack-cycle guard stops a still-held request from being taken twice
        end else if (i_req && o_init_done && !o_req_ack) begin
          ack_d = 1'b1;
          if (i_req_op < 3'(NUM_OPS)) begin
            op_d        = i_req_op;
            retry_d     = '0;
            boot_mode_d = 1'b0;
            wd_load     = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Finished wins over a coincident watchdog expiry
        if (i_i2c_finished) begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
          if (boot_mode_q && (o_i2c_op != LAST_OP)) begin
            op_d          = o_i2c_op + 3'd1;
            retry_d       = '0;
            gap_to_idle_d = 1'b0;
          end else begin
            if (boot_mode_q) begin
              done_d = 1'b1;
            end
            gap_to_idle_d = 1'b1;
          end
        end else if (wd_done) begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
          if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d       = retry_q + RT_W'(1);
            gap_to_idle_d = 1'b0;
          end else begin
            err_d         = 1'b1;
            fail_d        = o_i2c_op;
            gap_to_idle_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          if (gap_to_idle_q) begin
            state_d = ST_IDLE;
          end else begin
            wd_load = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a behavioural initializer model.
module tb_i2c_init_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_boot;
  logic       i_req;
  logic [2:0] i_req_op;
  logic       o_req_ack;
  logic       o_i2c_start;
  logic [2:0] o_i2c_op;
  logic       i_i2c_finished;
  logic       o_init_done;
  logic       o_busy;
  logic       o_error;
  logic [2:0] o_fail_op;

  i2c_init_sequencer #(
    .TIMEOUT_CYC (200),
    .MAX_RETRY   (2),
    .GAP_CYC     (16)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_boot         (i_boot),
    .i_req          (i_req),
    .i_req_op       (i_req_op),
    .o_req_ack      (o_req_ack),
    .o_i2c_start    (o_i2c_start),
    .o_i2c_op       (o_i2c_op),
    .i_i2c_finished (i_i2c_finished),
    .o_init_done    (o_init_done),
    .o_busy         (o_busy),
    .o_error        (o_error),
    .o_fail_op      (o_fail_op)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Initializer model configuration (written by the stimulus only)
  int resp_delay[7];
  int silent[7];

  // Model/monitor state (written by the model only)
  int attempts[7];
  int log_op[$];
  int log_hi[$];
  int log_lo[$];
  int log_done[$];
  int ack_cnt;
  int hi_cnt, lo_cnt, cur_op;
  logic prev_start;

  int exp_retry_ok[8] = '{0, 1, 2, 3, 3, 4, 5, 6};
  int exp_exhaust[8]  = '{0, 1, 2, 3, 4, 5, 5, 5};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Initializer model: answers resp_delay cycles after start rises, unless the
  // op still has silent attempts left; also logs every start pulse.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      i_i2c_finished = 1'b0;
      prev_start = 1'b0;
      hi_cnt = 0;
      lo_cnt = 0;
      cur_op = 0;
      ack_cnt = 0;
      foreach (attempts[k]) attempts[k] = 0;
      log_op.delete();
      log_hi.delete();
      log_lo.delete();
      log_done.delete();
    end else begin
      i_i2c_finished = 1'b0;
      if (o_req_ack) ack_cnt++;
      if (o_i2c_start) begin
        if (!prev_start) begin
          cur_op = int'(o_i2c_op);
          log_op.push_back(cur_op);
          log_lo.push_back(lo_cnt);
          hi_cnt = 0;
        end
        hi_cnt++;
        if (attempts[cur_op] >= silent[cur_op] && hi_cnt == resp_delay[cur_op])
          i_i2c_finished = 1'b1;
      end else begin
        if (prev_start) begin
          log_hi.push_back(hi_cnt);
          log_done.push_back(int'(o_init_done));
          attempts[cur_op]++;
          lo_cnt = 0;
        end
        lo_cnt++;
      end
      prev_start = o_i2c_start;
    end
  end

  task automatic set_defaults();
    for (int k = 0; k < 7; k++) begin
      resp_delay[k] = 50;
      silent[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic pulse_boot();
    @(negedge i_clk);
    i_boot = 1'b1;
    @(negedge i_clk);
    i_boot = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (!o_busy) begin
        ok = 1;
        break;
      end
    end
    check_eq(tag, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ok;
    i_rst_n = 1'b0;
    i_boot = 1'b0;
    i_req = 1'b0;
    i_req_op = 3'd0;
    set_defaults();
    repeat (3) @(negedge i_clk);

    // Reset state
    check_eq("rst_start", int'(o_i2c_start), 0);
    check_eq("rst_op", int'(o_i2c_op), 0);
    check_eq("rst_ack", int'(o_req_ack), 0);
    check_eq("rst_done", int'(o_init_done), 0);
    check_eq("rst_busy", int'(o_busy), 0);
    check_eq("rst_error", int'(o_error), 0);
    check_eq("rst_fail_op", int'(o_fail_op), 0);
    i_rst_n = 1'b1;

    // Boot with a responsive initializer
    pulse_boot();
    check_eq("boot_first_start", int'(o_i2c_start), 1);
    check_eq("boot_first_op", int'(o_i2c_op), 0);
    check_eq("boot_busy", int'(o_busy), 1);
    wait_idle("boot_idle", 3000);
    check_eq("boot_count", log_op.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("boot_op%0d", i), qget(log_op, i), i);
      check_eq($sformatf("boot_hi%0d", i), qget(log_hi, i), 50);
      if (i > 0) check_eq($sformatf("boot_gap%0d", i), qget(log_lo, i), 16);
    end
    check_eq("boot_done_before_last", qget(log_done, 5), 0);
    check_eq("boot_done_at_last_drop", qget(log_done, 6), 1);
    check_eq("boot_done", int'(o_init_done), 1);
    check_eq("boot_error", int'(o_error), 0);

    // One timeout on op 3, then success
    set_defaults();
    silent[3] = 1;
    do_reset();
    pulse_boot();
    wait_idle("retry_idle", 4000);
    check_eq("retry_count", log_op.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("retry_op%0d", i), qget(log_op, i), exp_retry_ok[i]);
    check_eq("retry_timeout_len", qget(log_hi, 3), 200);
    check_eq("retry_gap", qget(log_lo, 4), 16);
    check_eq("retry_second_len", qget(log_hi, 4), 50);
    check_eq("retry_done", int'(o_init_done), 1);
    check_eq("retry_error", int'(o_error), 0);

    // Op 5 never answers: retries exhausted
    set_defaults();
    silent[5] = 3;
    do_reset();
    pulse_boot();
    wait_idle("exhaust_idle", 4000);
    check_eq("exhaust_count", log_op.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("exhaust_op%0d", i), qget(log_op, i), exp_exhaust[i]);
    for (int i = 5; i < 8; i++)
      check_eq($sformatf("exhaust_hi%0d", i), qget(log_hi, i), 200);
    check_eq("exhaust_gap7", qget(log_lo, 7), 16);
    check_eq("exhaust_error", int'(o_error), 1);
    check_eq("exhaust_fail_op", int'(o_fail_op), 5);
    check_eq("exhaust_done", int'(o_init_done), 0);
    check_eq("exhaust_busy", int'(o_busy), 0);

    // Boot and request together: boot wins; request acked only after boot
    set_defaults();
    do_reset();
    @(negedge i_clk);
    i_boot = 1'b1;
    i_req = 1'b1;
    i_req_op = 3'd4;
    @(negedge i_clk);
    i_boot = 1'b0;
    check_eq("arb_no_ack_on_boot", int'(o_req_ack), 0);
    check_eq("arb_boot_op", int'(o_i2c_op), 0);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      if (o_req_ack) begin
        ok = 1;
        break;
      end
    end
    check_eq("arb_ack_seen", ok, 1);
    check_eq("arb_ack_done", int'(o_init_done), 1);
    check_eq("arb_ack_start", int'(o_i2c_start), 1);
    check_eq("arb_ack_op", int'(o_i2c_op), 4);
    i_req = 1'b0;
    wait_idle("arb_idle", 500);
    check_eq("arb_ack_count", ack_cnt, 1);
    check_eq("arb_issue_count", log_op.size(), 8);
    check_eq("arb_last_op", qget(log_op, 7), 4);
    check_eq("arb_last_hi", qget(log_hi, 7), 50);

    // Request with op 7: acked, nothing issued
    @(negedge i_clk);
    i_req = 1'b1;
    i_req_op = 3'd7;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_req_ack) begin
        ok = 1;
        break;
      end
    end
    i_req = 1'b0;
    check_eq("op7_ack_seen", ok, 1);
    check_eq("op7_no_start", int'(o_i2c_start), 0);
    repeat (3) @(negedge i_clk);
    check_eq("op7_busy", int'(o_busy), 0);
    check_eq("op7_ack_count", ack_cnt, 2);
    check_eq("op7_issue_count", log_op.size(), 8);

    // Reset in the middle of op 2
    set_defaults();
    do_reset();
    pulse_boot();
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_clk);
      if (o_i2c_start && o_i2c_op == 3'd2) begin
        ok = 1;
        break;
      end
    end
    check_eq("midrst_reached_op2", ok, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_start", int'(o_i2c_start), 0);
    check_eq("midrst_op", int'(o_i2c_op), 0);
    check_eq("midrst_busy", int'(o_busy), 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    pulse_boot();
    check_eq("midrst_restart_start", int'(o_i2c_start), 1);
    check_eq("midrst_restart_op", int'(o_i2c_op), 0);
    wait_idle("midrst_idle", 3000);
    check_eq("midrst_count", log_op.size(), 7);
    check_eq("midrst_done", int'(o_init_done), 1);

    // Finished arriving on the timeout edge counts as success
    set_defaults();
    resp_delay[2] = 200;
    do_reset();
    pulse_boot();
    wait_idle("simul_idle", 3000);
    check_eq("simul_count", log_op.size(), 7);
    check_eq("simul_op_after", qget(log_op, 3), 3);
    check_eq("simul_hi", qget(log_hi, 2), 200);
    check_eq("simul_done", int'(o_init_done), 1);
    check_eq("simul_error", int'(o_error), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
# i2c_init_sequencer

Controller that owns the codec-configuration I2C initializer (`I2cInitializer`) and sequences it. On a boot request it issues the seven codec operations (RESET, AAPC, DAPC, PDC, DAIF, SC, AC) one at a time over the initializer's start/finished handshake. Each operation has a timeout watchdog and bounded retry. After boot completes, it arbitrates single-operation runtime requests from the host side onto the same initializer.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 100000: cycles allowed from start assertion to `i_i2c_finished` before an attempt is declared failed.
- `MAX_RETRY`, default 2: extra attempts per operation after the first failure.
- `GAP_CYC`, default 16: idle cycles with start low between consecutive operations or attempts. Must be ≥1.

Ports:
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_boot` in 1: pulse; begins the full boot sequence.
- `i_req` in 1: runtime single-op request; level, held until acked.
- `i_req_op` in 3: operation code for `i_req`; valid 0..6.
- `o_req_ack` out 1: one-cycle pulse when `i_req` is accepted.
- `o_i2c_start` out 1: to initializer `i_start`.
- `o_i2c_op` out 3: to initializer `i_op`.
- `i_i2c_finished` in 1: from initializer `o_finished`.
- `o_init_done` out 1: level; boot sequence completed successfully.
- `o_busy` out 1: high in any state except IDLE.
- `o_error` out 1: sticky; an operation exhausted its retries.
- `o_fail_op` out 3: code of the operation that failed; valid while `o_error`=1.

## Operation
- States: IDLE, ISSUE, GAP.
- **Reset values:** all outputs 0, state IDLE, `o_i2c_op`=0.
- **IDLE, `i_boot`=1:**
  - clear `o_error`, `o_init_done`, and the op index; set mode BOOT; go to ISSUE with op 0.
  - `i_boot` has priority over `i_req` in the same cycle.
- **IDLE, `i_req`=1, `o_init_done`=1, `i_boot`=0:**
  - pulse `o_req_ack`, latch `i_req_op`, set mode SINGLE, go to ISSUE.
- **`i_req` when not accepted:** while `o_init_done`=0 or not in IDLE, `i_req` is not acked; the requester keeps holding it.
- **`i_req_op` 7:** acked and discarded; no transaction issued, state stays IDLE.
- **`i_boot` outside IDLE:** ignored.
- **ISSUE:**
  - `o_i2c_start`=1 and `o_i2c_op`=current op, held steady for the whole state.
  - Watchdog counts from 0 each cycle.
- **ISSUE, `i_i2c_finished` sampled 1:** success.
  - BOOT with op<6: op+1, retry count reset, go to GAP.
  - BOOT with op=6: set `o_init_done`, go to GAP, then return to IDLE.
  - SINGLE: go to GAP, then return to IDLE.
- **ISSUE, watchdog reaches `TIMEOUT_CYC` without finished:** attempt fails.
  - retry count < `MAX_RETRY`: retry+1, go to GAP, then reissue the same op.
  - otherwise: set `o_error`, load `o_fail_op`, go to GAP, then return to IDLE.
  - A boot abort leaves `o_init_done`=0.
- **Finished and timeout in the same cycle:** counts as success.
- **GAP:** `o_i2c_start`=0 for exactly `GAP_CYC` cycles, then go to the next target (ISSUE or IDLE).
- **Counter widths:**
  - watchdog: `$clog2(TIMEOUT_CYC+1)` bits, saturating.
  - gap counter: `$clog2(GAP_CYC+1)` bits.
  - retry counter: `$clog2(MAX_RETRY+1)` bits.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous); the initializer is reset by the same `i_rst_n`.

## Timing
- **Boot start:** `i_boot` sampled at edge k in IDLE → `o_i2c_start`=1 with op 0 from edge k+1.
- **Op completion:** `i_i2c_finished` sampled at edge j → `o_i2c_start`=0 from edge j+1; next op's start rises at edge j+1+`GAP_CYC`.
- **Timeout:** start rises at edge s → the attempt fails at edge s+`TIMEOUT_CYC`; start is low from the next cycle.
- **`o_req_ack`:** asserted in the cycle after `i_req` is sampled, together with the first cycle of `o_i2c_start`.
- **`o_init_done`:** set in the same cycle start drops after op 6 finishes.
- **`o_busy`:** falls when the GAP→IDLE transition completes.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `i2c_pkg` holds:
  - op enum `OP_RESET=0`, `OP_AAPC=1`, `OP_DAPC=2`, `OP_PDC=3`, `OP_DAIF=4`, `OP_SC=5`, `OP_AC=6`;
  - `NUM_OPS=7`;
  - the state enum.
- One sub-module, `cycle_timer`: a loadable down-counter with a `done` flag, instantiated twice (watchdog, gap).

## Test plan
- **Boot, responsive model:** model asserts finished 50 cycles after start → ops 0..6 issued in order, 7 start pulses each ≥50 cycles long, `GAP_CYC` low between them; `o_init_done`=1, `o_error`=0.
- **Single timeout then success:** `TIMEOUT_CYC`=200, model silent on the first attempt of op 3 → start drops at cycle 200, op 3 reissued after `GAP_CYC`, sequence completes, `o_init_done`=1.
- **Retries exhausted:** `MAX_RETRY`=2, model never answers op 5 → exactly 3 attempts of op 5; `o_error`=1, `o_fail_op`=5, `o_init_done`=0, `o_busy`=0.
- **Runtime arbitration:** `i_req` with op 4 held during boot → no ack until `o_init_done`; ack pulses one cycle later, op 4 issued once. `i_boot` and `i_req` in the same IDLE cycle → boot wins, no ack.
- **Reset mid-boot:** `i_rst_n` pulled low during op 2 → all outputs 0 immediately. A new `i_boot` after release restarts from op 0.
- **Simultaneous finished and timeout:** finished arrives on the timeout cycle → treated as success, no retry issued.
